// File: rtl/apb_req_arbiter.sv
// -----------------------------------------------------------------------------
// apb_req_arbiter
//
// Shares one APB master port between NB_REQ on-chip requesters. A round-robin
// arbiter picks a winner while idle, the request is latched and driven through
// the APB SETUP and ACCESS phases, and the completion (read data, error flag)
// is returned to the owning requester as a one-cycle rvalid pulse. Every
// ACCESS phase is bounded by a timeout so an unmapped address cannot hang the
// port.
//
// Ports
//   clk_i       clock, all state on the rising edge
//   rst_i       synchronous active-high reset
//   req_i       per-requester request level, held until granted
//   we_i        per-requester direction (1 = write)
//   addr_i      per-requester address
//   wdata_i     per-requester write data
//   gnt_o       one-hot grant, combinational, only while idle
//   rvalid_o    one-hot completion pulse to the owner, registered
//   rdata_o     read data, valid with rvalid_o, held until next completion
//   err_o       error flag (slave error or timeout), valid with rvalid_o
//   busy_o      high while a transfer is in SETUP or ACCESS
//   penable_o   APB enable to the node
//   pwrite_o    APB direction to the node
//   paddr_o     APB address to the node (IDLE_ADDR while idle)
//   pwdata_o    APB write data to the node
//   prdata_i    APB read data from the node
//   pready_i    APB ready from the node
//   pslverr_i   APB slave error from the node
// -----------------------------------------------------------------------------
module apb_req_arbiter #(
    parameter int                        NB_REQ         = 4,
    parameter int                        APB_ADDR_WIDTH = 32,
    parameter int                        APB_DATA_WIDTH = 32,
    parameter int                        TIMEOUT_CYCLES = 255,
    parameter logic [APB_ADDR_WIDTH-1:0] IDLE_ADDR      = 32'hFFFF_FFFF
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic [NB_REQ-1:0]                            req_i,
    input  logic [NB_REQ-1:0]                            we_i,
    input  logic [NB_REQ-1:0][APB_ADDR_WIDTH-1:0]        addr_i,
    input  logic [NB_REQ-1:0][APB_DATA_WIDTH-1:0]        wdata_i,
    output logic [NB_REQ-1:0]                            gnt_o,
    output logic [NB_REQ-1:0]                            rvalid_o,
    output logic [APB_DATA_WIDTH-1:0]                    rdata_o,
    output logic                                         err_o,
    output logic                                         busy_o,
    output logic                                         penable_o,
    output logic                                         pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0]                    paddr_o,
    output logic [APB_DATA_WIDTH-1:0]                    pwdata_o,
    input  logic [APB_DATA_WIDTH-1:0]                    prdata_i,
    input  logic                                         pready_i,
    input  logic                                         pslverr_i
);

    localparam int IDX_W = $clog2(NB_REQ);
    // A disabled timeout still needs a legal one-bit counter.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NB_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] owner;
    logic [CNT_W-1:0] tcnt;

    logic [IDX_W-1:0] win_idx;
    logic             win_valid;
    logic             timeout_hit;

    // Requester index base+offset, wrapped into 0..NB_REQ-1.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                   input int              offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NB_REQ) sum = sum - NB_REQ;
        return IDX_W'(sum);
    endfunction

    // Round-robin search: first requester with req set, from ptr upward.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NB_REQ; i++) begin
            if (!win_valid && req_i[wrap_idx(ptr, i)]) begin
                win_valid = 1'b1;
                win_idx   = wrap_idx(ptr, i);
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        if (state == ST_IDLE && win_valid) gnt_o[win_idx] = 1'b1;
    end

    assign busy_o      = (state != ST_IDLE);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt == TIMEOUT_VAL);

    // The latched request lives directly in the APB output registers, which
    // keeps paddr/pwrite/pwdata stable through SETUP and ACCESS for free.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register sees the pre-edge value of every other register.
        if (rst_i) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            owner     <= '0;
            tcnt      <= '0;
            paddr_o   <= IDLE_ADDR;
            pwrite_o  <= 1'b0;
            pwdata_o  <= '0;
            penable_o <= 1'b0;
            rvalid_o  <= '0;
            rdata_o   <= '0;
            err_o     <= 1'b0;
        end else begin
            rvalid_o <= '0;
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        state    <= ST_SETUP;
                        owner    <= win_idx;
                        paddr_o  <= addr_i[win_idx];
                        pwrite_o <= we_i[win_idx];
                        pwdata_o <= wdata_i[win_idx];
                        ptr      <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
                    end
                end
                ST_SETUP: begin
                    state     <= ST_ACCESS;
                    penable_o <= 1'b1;
                    tcnt      <= '0;
                end
                ST_ACCESS: begin
                    if (pready_i || timeout_hit) begin
                        state           <= ST_IDLE;
                        penable_o       <= 1'b0;
                        paddr_o         <= IDLE_ADDR;
                        pwrite_o        <= 1'b0;
                        pwdata_o        <= '0;
                        rvalid_o[owner] <= 1'b1;
                        // A real pready wins over a timeout landing the same cycle.
                        if (pready_i) begin
                            err_o   <= pslverr_i;
                            rdata_o <= pwrite_o ? '0 : prdata_i;
                        end else begin
                            err_o   <= 1'b1;
                            rdata_o <= '0;
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_req_arbiter
//
// Self-checking bench for apb_req_arbiter (NB_REQ=4, TIMEOUT_CYCLES=8).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. A per-cycle vector table covers a single read, a write with
// wait states, a slave error and a completion coinciding with a new grant;
// hand-written sequences cover fairness, timeout and reset mid-access.
// -----------------------------------------------------------------------------
module tb_apb_req_arbiter;

    localparam logic [31:0] IDLE_A = 32'hFFFF_FFFF;

    logic             clk_i;
    logic             rst_i;
    logic [3:0]       req_i;
    logic [3:0]       we_i;
    logic [3:0][31:0] addr_i;
    logic [3:0][31:0] wdata_i;
    logic [3:0]       gnt_o;
    logic [3:0]       rvalid_o;
    logic [31:0]      rdata_o;
    logic             err_o;
    logic             busy_o;
    logic             penable_o;
    logic             pwrite_o;
    logic [31:0]      paddr_o;
    logic [31:0]      pwdata_o;
    logic [31:0]      prdata_i;
    logic             pready_i;
    logic             pslverr_i;

    int n_checks = 0;
    int n_fail   = 0;

    apb_req_arbiter #(
        .NB_REQ         (4),
        .APB_ADDR_WIDTH (32),
        .APB_DATA_WIDTH (32),
        .TIMEOUT_CYCLES (8),
        .IDLE_ADDR      (IDLE_A)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .gnt_o     (gnt_o),
        .rvalid_o  (rvalid_o),
        .rdata_o   (rdata_o),
        .err_o     (err_o),
        .busy_o    (busy_o),
        .penable_o (penable_o),
        .pwrite_o  (pwrite_o),
        .paddr_o   (paddr_o),
        .pwdata_o  (pwdata_o),
        .prdata_i  (prdata_i),
        .pready_i  (pready_i),
        .pslverr_i (pslverr_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  we;
        logic        rdy;
        logic        serr;
        logic [31:0] prd;
        logic [3:0]  e_gnt;
        logic [3:0]  e_rvalid;
        logic        e_pen;
        logic        e_busy;
        logic [31:0] e_paddr;
        logic        e_pwrite;
        logic [31:0] e_pwdata;
        logic [31:0] e_rdata;
        logic        e_err;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] we, input logic rdy,
                         input logic serr, input logic [31:0] prd);
        req_i     = req;
        we_i      = we;
        pready_i  = rdy;
        pslverr_i = serr;
        prdata_i  = prd;
    endtask

    // Watchdog: the bench is cycle-exact, this only guards against a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0]  eg;
        logic [3:0]  er;

        addr_i[0]  = 32'h1A10_0004;
        addr_i[1]  = 32'h1A10_0100;
        addr_i[2]  = 32'h1A10_0208;
        addr_i[3]  = 32'h3000_0000;   // unmapped: node never answers
        wdata_i[0] = 32'h0000_1111;
        wdata_i[1] = 32'h0000_2222;
        wdata_i[2] = 32'h55AA_55AA;
        wdata_i[3] = 32'h0000_4444;

        //             req      we       rdy   serr  prdata          gnt      rvalid   pen   busy  paddr          pwr   pwdata         rdata          err
        // single read by requester 0
        vecs[0]  = '{4'b0001, 4'b0000, 1'b1, 1'b0, 32'hDEAD_BEEF, 4'b0001, 4'b0000, 1'b0, 1'b0, IDLE_A,        1'b0, 32'h0,         32'h0,         1'b0};
        vecs[1]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 32'hDEAD_BEEF, 4'b0000, 4'b0000, 1'b0, 1'b1, 32'h1A10_0004, 1'b0, 32'h0000_1111, 32'h0,         1'b0};
        vecs[2]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 32'hDEAD_BEEF, 4'b0000, 4'b0000, 1'b1, 1'b1, 32'h1A10_0004, 1'b0, 32'h0000_1111, 32'h0,         1'b0};
        vecs[3]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,         4'b0000, 4'b0001, 1'b0, 1'b0, IDLE_A,        1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0};
        // write by requester 2 with four wait states; req1 waits meanwhile,
        // and pslverr/prdata during wait cycles must be ignored
        vecs[4]  = '{4'b0100, 4'b0100, 1'b0, 1'b0, 32'h0,         4'b0100, 4'b0000, 1'b0, 1'b0, IDLE_A,        1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[5]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 32'hBAD0_BAD0, 4'b0000, 4'b0000, 1'b0, 1'b1, 32'h1A10_0208, 1'b1, 32'h55AA_55AA, 32'hDEAD_BEEF, 1'b0};
        vecs[6]  = '{4'b0010, 4'b0000, 1'b0, 1'b1, 32'hBAD0_BAD0, 4'b0000, 4'b0000, 1'b1, 1'b1, 32'h1A10_0208, 1'b1, 32'h55AA_55AA, 32'hDEAD_BEEF, 1'b0};
        vecs[7]  = vecs[6];
        vecs[8]  = vecs[6];
        vecs[9]  = vecs[6];
        vecs[10] = '{4'b0010, 4'b0000, 1'b1, 1'b0, 32'hCAFE_F00D, 4'b0000, 4'b0000, 1'b1, 1'b1, 32'h1A10_0208, 1'b1, 32'h55AA_55AA, 32'hDEAD_BEEF, 1'b0};
        // write completes (rdata 0) in the same cycle requester 1 is granted
        vecs[11] = '{4'b0010, 4'b0000, 1'b0, 1'b0, 32'h0,         4'b0010, 4'b0100, 1'b0, 1'b0, IDLE_A,        1'b0, 32'h0,         32'h0,         1'b0};
        // read by requester 1 answered with a slave error
        vecs[12] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,         4'b0000, 4'b0000, 1'b0, 1'b1, 32'h1A10_0100, 1'b0, 32'h0000_2222, 32'h0,         1'b0};
        vecs[13] = '{4'b0000, 4'b0000, 1'b1, 1'b1, 32'h0000_1234, 4'b0000, 4'b0000, 1'b1, 1'b1, 32'h1A10_0100, 1'b0, 32'h0000_2222, 32'h0,         1'b0};
        vecs[14] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,         4'b0000, 4'b0010, 1'b0, 1'b0, IDLE_A,        1'b0, 32'h0,         32'h0000_1234, 1'b1};
        // idle: pready/pslverr outside ACCESS are ignored, results hold
        vecs[15] = '{4'b0000, 4'b0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 4'b0000, 4'b0000, 1'b0, 1'b0, IDLE_A,        1'b0, 32'h0,         32'h0000_1234, 1'b1};

        // ---------------- reset state ----------------
        rst_i = 1'b1;
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
        next_cycle();
        next_cycle();
        @(negedge clk_i);
        check("rst gnt",     32'(gnt_o),     32'h0);
        check("rst rvalid",  32'(rvalid_o),  32'h0);
        check("rst rdata",   rdata_o,        32'h0);
        check("rst err",     32'(err_o),     32'h0);
        check("rst busy",    32'(busy_o),    32'h0);
        check("rst penable", 32'(penable_o), 32'h0);
        check("rst pwrite",  32'(pwrite_o),  32'h0);
        check("rst pwdata",  pwdata_o,       32'h0);
        check("rst paddr",   paddr_o,        IDLE_A);

        // ---------------- vector table ----------------
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            rst_i = 1'b0;
            drive(vecs[i].req, vecs[i].we, vecs[i].rdy, vecs[i].serr, vecs[i].prd);
            @(negedge clk_i);
            check($sformatf("v%0d gnt", i),     32'(gnt_o),     32'(vecs[i].e_gnt));
            check($sformatf("v%0d rvalid", i),  32'(rvalid_o),  32'(vecs[i].e_rvalid));
            check($sformatf("v%0d penable", i), 32'(penable_o), 32'(vecs[i].e_pen));
            check($sformatf("v%0d busy", i),    32'(busy_o),    32'(vecs[i].e_busy));
            check($sformatf("v%0d paddr", i),   paddr_o,        vecs[i].e_paddr);
            check($sformatf("v%0d pwrite", i),  32'(pwrite_o),  32'(vecs[i].e_pwrite));
            check($sformatf("v%0d pwdata", i),  pwdata_o,       vecs[i].e_pwdata);
            check($sformatf("v%0d rdata", i),   rdata_o,        vecs[i].e_rdata);
            check($sformatf("v%0d err", i),     32'(err_o),     32'(vecs[i].e_err));
        end

        // ---------------- fairness: all four requesting ----------------
        next_cycle();
        rst_i = 1'b1;
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
        for (int c = 0; c <= 24; c++) begin
            next_cycle();
            rst_i = 1'b0;
            drive((c < 24) ? 4'b1111 : 4'b0000, 4'b0000, 1'b1, 1'b0, 32'hA5A5_0000 + 32'(c));
            @(negedge clk_i);
            eg = (c % 3 == 0 && c < 24) ? 4'(1 << ((c / 3) % 4)) : 4'b0000;
            er = (c % 3 == 0 && c > 0)  ? 4'(1 << (((c / 3) - 1) % 4)) : 4'b0000;
            check($sformatf("rr c%0d gnt", c),    32'(gnt_o),    32'(eg));
            check($sformatf("rr c%0d rvalid", c), 32'(rvalid_o), 32'(er));
            if (c % 3 == 0 && c > 0)
                check($sformatf("rr c%0d rdata", c), rdata_o, 32'hA5A5_0000 + 32'(c - 1));
        end

        // ---------------- timeout on unmapped address, then normal read ----------------
        for (int c = 0; c <= 14; c++) begin
            next_cycle();
            if (c == 0)
                drive(4'b1000, 4'b0000, 1'b0, 1'b1, 32'hBAD0_BAD0);
            else if (c < 11)
                drive(4'b0000, 4'b0000, 1'b0, 1'b1, 32'hBAD0_BAD0);
            else if (c == 11)
                drive(4'b0001, 4'b0000, 1'b0, 1'b0, 32'h0);
            else if (c == 13)
                drive(4'b0000, 4'b0000, 1'b1, 1'b0, 32'h0000_600D);
            else
                drive(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
            @(negedge clk_i);
            eg = (c == 0) ? 4'b1000 : (c == 11) ? 4'b0001 : 4'b0000;
            er = (c == 11) ? 4'b1000 : (c == 14) ? 4'b0001 : 4'b0000;
            check($sformatf("to c%0d gnt", c),    32'(gnt_o),    32'(eg));
            check($sformatf("to c%0d rvalid", c), 32'(rvalid_o), 32'(er));
            check($sformatf("to c%0d busy", c),   32'(busy_o),
                  32'((c >= 1 && c <= 10) || (c >= 12 && c <= 13)));
            if (c == 10) check("to c10 penable", 32'(penable_o), 32'h1);
            if (c == 11) begin
                check("to c11 rdata", rdata_o,    32'h0);
                check("to c11 err",   32'(err_o), 32'h1);
            end
            if (c == 14) begin
                check("to c14 rdata", rdata_o,    32'h0000_600D);
                check("to c14 err",   32'(err_o), 32'h0);
            end
        end

        // ---------------- reset in the 2nd ACCESS wait cycle ----------------
        // Pointer is 1 here; req2 is granted, then req1 and req3 wait.
        for (int c = 0; c <= 7; c++) begin
            next_cycle();
            rst_i = (c == 3);
            if (c == 0)
                drive(4'b0100, 4'b0100, 1'b0, 1'b0, 32'h0);
            else if (c <= 4)
                drive(4'b1010, 4'b0000, 1'b0, 1'b0, 32'h0);
            else if (c == 6)
                drive(4'b0000, 4'b0000, 1'b1, 1'b0, 32'h0000_0077);
            else
                drive(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
            @(negedge clk_i);
            eg = (c == 0) ? 4'b0100 : (c == 4) ? 4'b0010 : 4'b0000;
            er = (c == 7) ? 4'b0010 : 4'b0000;
            check($sformatf("mr c%0d gnt", c),    32'(gnt_o),    32'(eg));
            check($sformatf("mr c%0d rvalid", c), 32'(rvalid_o), 32'(er));
            if (c == 1) check("mr c1 pwrite",  32'(pwrite_o),  32'h1);
            if (c == 3) check("mr c3 penable", 32'(penable_o), 32'h1);
            if (c == 4) begin
                check("mr c4 penable", 32'(penable_o), 32'h0);
                check("mr c4 paddr",   paddr_o,        IDLE_A);
                check("mr c4 busy",    32'(busy_o),    32'h0);
                check("mr c4 rdata",   rdata_o,        32'h0);
            end
            if (c == 5) check("mr c5 paddr", paddr_o, 32'h1A10_0100);
            if (c == 7) check("mr c7 rdata", rdata_o, 32'h0000_0077);
        end

        next_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
